// File: rtl/i2s_tx.sv
// I2S (Philips) stereo transmitter: one-pair holding register feeding a 64-bit frame shifter timed by SCK/WS.
// Optional macro I2S_TX_UNDERRUN_EN: count underruns and repeat the last pair instead of sending silence.
`timescale 1ns/1ps

module i2s_tx #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sck,
   input  logic             i_ws,
   input  logic [WIDTH-1:0] i_left,
   input  logic [WIDTH-1:0] i_right,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sd,
   output logic             o_frame_start,
   output logic             o_sync_err,
   output logic [15:0]      o_underruns
);

   localparam int unsigned SLOT_W  = 32;
   localparam int unsigned FRAME_W = 2 * SLOT_W;
   localparam int unsigned PAD_W   = SLOT_W - WIDTH;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned UND_W   = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_sck_d;
   logic                 r_ws_last;
   logic [FRAME_W-1:0]   r_shift;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_sd;
   logic                 r_frame_start;
   logic                 r_sync_err;
   logic                 r_empty;
   logic [WIDTH-1:0]     r_hold_l;
   logic [WIDTH-1:0]     r_hold_r;

   state_t               w_nxt_state;
   logic                 w_nxt_ws_last;
   logic [FRAME_W-1:0]   w_nxt_shift;
   logic [CNT_W-1:0]     w_nxt_cnt;
   logic                 w_nxt_sd;
   logic                 w_nxt_frame_start;
   logic                 w_nxt_sync_err;
   logic                 w_nxt_empty;
   logic [WIDTH-1:0]     w_nxt_hold_l;
   logic [WIDTH-1:0]     w_nxt_hold_r;

   logic                 w_fall;
   logic                 w_start;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_under_l;
   logic [WIDTH-1:0]     w_under_r;
   logic [WIDTH-1:0]     w_pair_l;
   logic [WIDTH-1:0]     w_pair_r;
   logic [SLOT_W-1:0]    w_slot_l;
   logic [SLOT_W-1:0]    w_slot_r;
   logic [FRAME_W-1:0]   w_frame;

`ifdef I2S_TX_UNDERRUN_EN
   logic [WIDTH-1:0]     r_last_l;
   logic [WIDTH-1:0]     r_last_r;
   logic [UND_W-1:0]     r_und;
   logic [WIDTH-1:0]     w_nxt_last_l;
   logic [WIDTH-1:0]     w_nxt_last_r;
   logic [UND_W-1:0]     w_nxt_und;

   assign w_under_l   = r_last_l;
   assign w_under_r   = r_last_r;
   assign o_underruns = r_und;
`else
   assign w_under_l   = '0;
   assign w_under_r   = '0;
   assign o_underruns = UND_W'(0);
`endif

   // SCK/WS are plain data in this domain; only the SCK fall is an active edge.
   assign w_fall   = r_sck_d & ~i_sck;
   assign w_start  = w_fall & ~i_ws & r_ws_last;
   assign w_accept = i_valid & r_empty;

   // Hold contents as of before this CLK decide the frame; an empty hold means underrun.
   assign w_pair_l = r_empty ? w_under_l : r_hold_l;
   assign w_pair_r = r_empty ? w_under_r : r_hold_r;
   assign w_slot_l = SLOT_W'(w_pair_l) << PAD_W;
   assign w_slot_r = SLOT_W'(w_pair_r) << PAD_W;
   assign w_frame  = {w_slot_l, w_slot_r};

   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_ws_last     = r_ws_last;
      w_nxt_shift       = r_shift;
      w_nxt_cnt         = r_cnt;
      w_nxt_sd          = r_sd;
      w_nxt_frame_start = 1'b0;
      w_nxt_sync_err    = 1'b0;
      w_nxt_empty       = r_empty;
      w_nxt_hold_l      = r_hold_l;
      w_nxt_hold_r      = r_hold_r;
`ifdef I2S_TX_UNDERRUN_EN
      w_nxt_last_l      = r_last_l;
      w_nxt_last_r      = r_last_r;
      w_nxt_und         = r_und;
`endif

      if (w_fall) begin
         w_nxt_ws_last = i_ws;
         w_nxt_cnt     = w_start ? '0 : r_cnt + CNT_W'(1);
      end

      case (r_state)
         ST_IDLE: begin
            w_nxt_sd = 1'b0;
            if (w_start) begin
               w_nxt_state       = ST_RUN;
               w_nxt_shift       = w_frame;
               w_nxt_frame_start = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_fall) begin
               w_nxt_sd    = r_shift[FRAME_W-1];
               w_nxt_shift = w_start ? w_frame : (r_shift << 1);
               if (w_start) begin
                  w_nxt_frame_start = 1'b1;
                  w_nxt_sync_err    = (r_cnt != CNT_LAST);
               end
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase

      // Hold is drained by a start, then refilled by a same-CLK accept for the next frame.
      if (w_start) begin
         w_nxt_empty = 1'b1;
`ifdef I2S_TX_UNDERRUN_EN
         if (!r_empty) begin
            w_nxt_last_l = r_hold_l;
            w_nxt_last_r = r_hold_r;
         end else if ((r_state == ST_RUN) && (r_und != '1)) begin
            w_nxt_und = r_und + UND_W'(1);
         end
`endif
      end

      if (w_accept) begin
         w_nxt_hold_l = i_left;
         w_nxt_hold_r = i_right;
         w_nxt_empty  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_sck_d       <= 1'b0;
         r_ws_last     <= 1'b0;
         r_shift       <= '0;
         r_cnt         <= '0;
         r_sd          <= 1'b0;
         r_frame_start <= 1'b0;
         r_sync_err    <= 1'b0;
         r_empty       <= 1'b1;
         r_hold_l      <= '0;
         r_hold_r      <= '0;
`ifdef I2S_TX_UNDERRUN_EN
         r_last_l      <= '0;
         r_last_r      <= '0;
         r_und         <= '0;
`endif
      end else begin
         r_state       <= w_nxt_state;
         r_sck_d       <= i_sck;
         r_ws_last     <= w_nxt_ws_last;
         r_shift       <= w_nxt_shift;
         r_cnt         <= w_nxt_cnt;
         r_sd          <= w_nxt_sd;
         r_frame_start <= w_nxt_frame_start;
         r_sync_err    <= w_nxt_sync_err;
         r_empty       <= w_nxt_empty;
         r_hold_l      <= w_nxt_hold_l;
         r_hold_r      <= w_nxt_hold_r;
`ifdef I2S_TX_UNDERRUN_EN
         r_last_l      <= w_nxt_last_l;
         r_last_r      <= w_nxt_last_r;
         r_und         <= w_nxt_und;
`endif
      end
   end

   assign o_ready       = r_empty;
   assign o_sd          = r_sd;
   assign o_frame_start = r_frame_start;
   assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: SCK = CLK/8, WS every 32 falls, DAC model decodes sd on SCK rise against a frame scoreboard.
`timescale 1ns/1ps

module tb_i2s_tx;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned FRAME_LEN = 64;
   localparam int unsigned SHORT_LEN = 40;
`ifdef I2S_TX_UNDERRUN_EN
   localparam bit UND_EN = 1'b1;
`else
   localparam bit UND_EN = 1'b0;
`endif

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             sck   = 1'b1;
   logic             ws    = 1'b1;
   logic             valid = 1'b0;
   logic [WIDTH-1:0] left  = '0;
   logic [WIDTH-1:0] right = '0;
   logic             o_ready;
   logic             o_sd;
   logic             o_frame_start;
   logic             o_sync_err;
   logic [15:0]      o_underruns;

   i2s_tx #(.WIDTH(WIDTH)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sck         (sck),
      .i_ws          (ws),
      .i_left        (left),
      .i_right       (right),
      .i_valid       (valid),
      .o_ready       (o_ready),
      .o_sd          (o_sd),
      .o_frame_start (o_frame_start),
      .o_sync_err    (o_sync_err),
      .o_underruns   (o_underruns)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Frame-level reference: hold register, frame starts and the expected frame per start.
   bit          m_sck_d = 1'b0, m_ws_last = 1'b0, m_full = 1'b0, m_run = 1'b0;
   bit          m_fs = 1'b0, m_se = 1'b0, m_acc = 1'b0;
   logic [5:0]  m_cnt = '0;
   logic [15:0] m_hl = '0, m_hr = '0, m_ll = '0, m_lr = '0, m_und = '0;
   int          m_starts = 0, m_serr_cnt = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) begin : model
      bit          fall, start;
      logic [31:0] fr;
      if (rst) begin
         m_sck_d = 1'b0; m_ws_last = 1'b0; m_full = 1'b0; m_run = 1'b0;
         m_fs = 1'b0; m_se = 1'b0; m_acc = 1'b0; m_cnt = '0;
         m_hl = '0; m_hr = '0; m_ll = '0; m_lr = '0; m_und = '0;
         exp_q.delete();
      end else begin
         fall  = m_sck_d & ~sck;
         start = fall & ~ws & m_ws_last;
         m_fs  = start;
         m_se  = start & m_run & (m_cnt != 6'd63);
         m_acc = valid & ~m_full;
         if (m_se) m_serr_cnt++;
         if (start) begin
            if (m_full) begin
               fr = {m_hl, m_hr};
               m_ll = m_hl; m_lr = m_hr;
            end else begin
               fr = UND_EN ? {m_ll, m_lr} : 32'h0;
               if (UND_EN && m_run && m_und != 16'hFFFF) m_und = m_und + 16'd1;
            end
            exp_q.push_back(fr);
            m_full = 1'b0;
            m_run  = 1'b1;
            m_starts++;
         end
         if (fall) begin
            m_cnt     = start ? 6'd0 : m_cnt + 6'd1;
            m_ws_last = ws;
         end
         if (m_acc) begin
            m_hl = left; m_hr = right; m_full = 1'b1;
         end
         m_sck_d = sck;
      end
   end

   int n_serr_seen = 0;
   always @(negedge clk) begin
      chk("frame_start", 32'(o_frame_start), 32'(m_fs));
      chk("sync_err",    32'(o_sync_err),    32'(m_se));
      chk("in_ready",    32'(o_ready),       32'(!m_full));
      chk("underruns",   32'(o_underruns),   32'(m_und));
      if (o_sync_err) n_serr_seen++;
   end

   // SCK/WS generator plus DAC model sampling sd on each SCK rise.
   int   fall_idx   = 40;
   int   cur_len    = FRAME_LEN;
   bit   short_req  = 1'b0;
   bit   short_done = 1'b0;
   bit   dec_skip   = 1'b0;
   int   n_dec      = 0;
   event ev_fall0;

   initial begin : gen
      logic [63:0] rx;
      logic [31:0] fr;
      rx = '0;
      forever begin
         repeat (4) @(negedge clk);
         sck      = 1'b0;
         fall_idx = (fall_idx + 1 >= cur_len) ? 0 : fall_idx + 1;
         if (fall_idx == 0) begin
            cur_len = (short_req && !short_done) ? SHORT_LEN : FRAME_LEN;
            if (cur_len == SHORT_LEN) short_done = 1'b1;
         end
         ws = (fall_idx >= cur_len / 2);
         if (fall_idx == 0) ->ev_fall0;
         repeat (4) @(negedge clk);
         sck = 1'b1;
         rx  = {rx[62:0], o_sd};
         if (!m_run) chk("idle_sd", 32'(o_sd), 32'h0);
         if (fall_idx == 0) begin
            if (exp_q.size() >= 2) begin
               fr = exp_q.pop_front();
               if (!dec_skip) begin
                  n_dec++;
                  chk("dec_left",  32'(rx[63:48]), 32'(fr[31:16]));
                  chk("dec_lpad",  32'(rx[47:32]), 32'h0);
                  chk("dec_right", 32'(rx[31:16]), 32'(fr[15:0]));
                  chk("dec_rpad",  32'(rx[15:0]),  32'h0);
               end
            end
            dec_skip = (cur_len != FRAME_LEN);
         end
      end
   end

   task automatic offer(input logic [15:0] l, input logic [15:0] r);
      int t;
      t     = 0;
      left  = l;
      right = r;
      valid = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!m_acc && t < 3000);
      chk("accept", 32'(m_acc), 32'h1);
      valid = 1'b0;
   endtask

   task automatic wait_starts(input int n);
      int target, t;
      target = m_starts + n;
      t      = 0;
      while (m_starts < target && t < n * 700) begin
         @(negedge clk);
         t++;
      end
      chk("starts", 32'(m_starts >= target), 32'h1);
   endtask

   initial begin : main
      int t;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_sd",    32'(o_sd),        32'h0);
      chk("rst_ready", 32'(o_ready),     32'h1);
      chk("rst_und",   32'(o_underruns), 32'h0);
      rst = 1'b0;

      // Pair offered before the first WS fall, then a pair followed by a 3-frame gap.
      offer(16'hA5C3, 16'h0F0F);
      offer(16'h1234, 16'h5678);
      wait_starts(4);
      chk("und_after_gap", 32'(o_underruns), UND_EN ? 32'd3 : 32'd0);

      // Offer lands on the very CLK of frame_start with hold empty.
      @(ev_fall0);
      offer(16'hAAAA, 16'h5555);
      chk("t3_ready_low", 32'(o_ready), 32'h0);

      // Back-to-back ramp, then one short frame in the middle of more ramp data.
      for (int i = 0; i < 8; i++) offer(16'(2 * i), 16'(2 * i + 1));
      short_req = 1'b1;
      for (int i = 8; i < 12; i++) offer(16'(2 * i), 16'(2 * i + 1));
      wait_starts(2);
      chk("serr_seen",  32'(n_serr_seen), 32'd1);
      chk("serr_model", 32'(m_serr_cnt),  32'd1);

      // Reset in the left slot, then a clean restart at the next WS fall.
      t = 0;
      while (fall_idx != 10 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      chk("reach_left_slot", 32'(fall_idx), 32'd10);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sd",    32'(o_sd),    32'h0);
      chk("midrst_ready", 32'(o_ready), 32'h1);
      rst = 1'b0;
      offer(16'hBEEF, 16'h1357);
      wait_starts(3);
      chk("frames_decoded", 32'(n_dec >= 12), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      n_fail++;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
